// File: rtl/rhs_pkg.sv
// rhs_pkg: shared types and constants for the RHS headstage SPI link.
// Used by the SPI master, its capture block and the benches.
package rhs_pkg;

  localparam int FRAME_BITS = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_TAIL,
    S_RECOVER
  } spi_state_t;

  localparam logic [1:0] RHS_OP_CONVERT = 2'b00;
  localparam logic [1:0] RHS_OP_WRITE   = 2'b10;
  localparam logic [1:0] RHS_OP_READ    = 2'b11;

  localparam logic [31:0] RHS_CMD_CLEAR = 32'h6a00_0000;
  localparam logic [31:0] RHS_CMD_CALIB = 32'h5500_0000;

  function automatic logic [31:0] rhs_read(input logic [7:0] addr);
    return {RHS_OP_READ, 6'd0, addr, 16'd0};
  endfunction

endpackage

// File: rtl/rhs_miso_capture.sv
// rhs_miso_capture: samples MISO at the delayed SCLK-rise slots
// and assembles the 32-bit reply into a one-cycle result pulse.
module rhs_miso_capture
  import rhs_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DELAY_W      = 4,
  parameter int TW           = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TW-1:0]      t,
  input  logic [DELAY_W-1:0] delay,
  input  logic               miso,
  output logic [31:0]        rsp_data,
  output logic               rsp_valid
);

  localparam int NB_W = $clog2(FRAME_BITS + 1);
  localparam logic [NB_W-1:0] NB_END = NB_W'(FRAME_BITS);
  localparam logic [NB_W-1:0] NB_LST = NB_W'(FRAME_BITS - 1);

  logic [NB_W-1:0] nb;
  logic [30:0]     sh;
  logic [TW-1:0]   due;
  logic            hit;

  // Bit nb is due half a bit period plus the cable delay into its slot.
  always_comb begin
    due = TW'(delay)
        + TW'(nb) * TW'(CLKS_PER_BIT)
        + TW'(CLKS_PER_BIT / 2);
    hit = (nb != NB_END) && (t == due);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nb        <= NB_END;
      sh        <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (start) begin
        nb <= '0;
      end else if (hit) begin
        sh <= {sh[29:0], miso};
        nb <= nb + NB_W'(1);
        if (nb == NB_LST) begin
          rsp_data  <= {sh, miso};
          rsp_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rhs_spi_master.sv
// rhs_spi_master: 32-bit SPI initiator for one RHS headstage link.
// Serialises commands MSB-first and returns the delayed-capture reply.
module rhs_spi_master
  import rhs_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int CS_HIGH_CLKS = 8,
  parameter int DELAY_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        cmd_data,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DELAY_W-1:0] miso_delay,
  output logic [31:0]        rsp_data,
  output logic               rsp_valid,
  output logic               busy,
  output logic               CS,
  output logic               SCLK,
  output logic               MOSI,
  input  logic               MISO
);

  localparam int FRAME_CLKS = FRAME_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(FRAME_CLKS + 2**DELAY_W + CS_HIGH_CLKS + 1);
  localparam int PW = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] T_LAST  = TW'(FRAME_CLKS - 1);
  localparam logic [TW-1:0] T_FREE  = TW'(FRAME_CLKS + CS_HIGH_CLKS - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(CLKS_PER_BIT / 2);

  spi_state_t         state;
  logic [TW-1:0]      t;
  logic [PW-1:0]      ph;
  logic [PW-1:0]      ph_n;
  logic [30:0]        sh;
  logic [DELAY_W-1:0] dly;
  logic               start;

  assign start = cmd_valid && cmd_ready;
  assign busy  = !cmd_ready;
  assign ph_n  = (ph == PH_LAST) ? '0 : ph + PW'(1);

  // Pins are registered from the next-cycle phase so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      t         <= '0;
      ph        <= '0;
      sh        <= '0;
      dly       <= '0;
      cmd_ready <= 1'b1;
      CS        <= 1'b1;
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
    end else begin
      if (state != S_IDLE) t <= t + TW'(1);
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            state     <= S_SHIFT;
            t         <= '0;
            ph        <= '0;
            sh        <= cmd_data[30:0];
            dly       <= miso_delay;
            cmd_ready <= 1'b0;
            CS        <= 1'b0;
            MOSI      <= cmd_data[31];
          end
        end
        S_SHIFT: begin
          if (t == T_LAST) begin
            state <= rsp_valid ? S_RECOVER : S_TAIL;
            CS    <= 1'b1;
            SCLK  <= 1'b0;
            MOSI  <= 1'b0;
          end else begin
            ph   <= ph_n;
            SCLK <= (ph_n >= PH_HALF);
            if (ph_n == '0) begin
              sh   <= {sh[29:0], 1'b0};
              MOSI <= sh[30];
            end
          end
        end
        S_TAIL: begin
          if (rsp_valid) begin
            if (t >= T_FREE) begin
              state     <= S_IDLE;
              cmd_ready <= 1'b1;
            end else begin
              state <= S_RECOVER;
            end
          end
        end
        S_RECOVER: begin
          if (t >= T_FREE) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  rhs_miso_capture #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DELAY_W     (DELAY_W),
    .TW          (TW)
  ) u_cap (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .t        (t),
    .delay    (dly),
    .miso     (MISO),
    .rsp_data (rsp_data),
    .rsp_valid(rsp_valid)
  );

endmodule
